// File: rtl/mini_alu_16bit_mul_arb.sv
// mini_alu_16bit_mul_arb
// Round-robin front end that shares one external multiplier between two
// requesters. A granted request latches its operands, which drive the
// multiplier through mul_data0/mul_data1. The block then waits for mul_valid,
// or gives up after TIMEOUT edges, and presents a single response.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/a/b, reqN_ready    requester N operand handshake (N = 0, 1)
//   mul_data0, mul_data1          registered operands to the shared multiplier
//   mul_product/overflow/valid    multiplier result
//   rsp_valid/id/product/
//   rsp_overflow/err, rsp_ready   response handshake
//   busy                          high whenever the FSM is not idle
module mini_alu_16bit_mul_arb #(
  parameter int MUL_LAT = 1,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic [15:0] mul_data0,
  output logic [15:0] mul_data1,
  input  logic [31:0] mul_product,
  input  logic        mul_overflow,
  input  logic        mul_valid,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_product,
  output logic        rsp_overflow,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [4:0] LAT_W = 5'(MUL_LAT);
  localparam logic [4:0] TMO_W = 5'(TIMEOUT);

  state_t     state;
  logic [3:0] cnt;
  logic       id_q;
  logic       last_gnt;
  logic       grant0;
  logic       grant_any;
  logic [4:0] cnt_plus1;

  // Wait counter saturates rather than wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Requester 0 wins when it is alone or when requester 1 was served last.
  assign grant0     = req0_valid && (!req1_valid || last_gnt);
  assign grant_any  = (req0_valid || req1_valid) && (state == IDLE) && !rst;
  assign req0_ready = grant_any && grant0;
  assign req1_ready = grant_any && !grant0;
  assign cnt_plus1  = {1'b0, cnt} + 5'd1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      id_q         <= 1'b0;
      last_gnt     <= 1'b1;
      mul_data0    <= 16'd0;
      mul_data1    <= 16'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_product  <= 32'd0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mul_data0 <= grant0 ? req0_a : req1_a;
            mul_data1 <= grant0 ? req0_b : req1_b;
            id_q      <= !grant0;
            cnt       <= 4'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A product arriving on the timeout edge still counts as a capture.
          if ((cnt_plus1 >= LAT_W) && mul_valid) begin
            rsp_product  <= mul_product;
            rsp_overflow <= mul_overflow;
            rsp_err      <= 1'b0;
            rsp_id       <= id_q;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (cnt_plus1 == TMO_W) begin
            rsp_product  <= 32'd0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
            rsp_id       <= id_q;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_gnt  <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_16bit_mul_arb.sv
module tb_mini_alu_16bit_mul_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [15:0] mul_data0, mul_data1;
  logic [31:0] mul_product;
  logic        mul_overflow, mul_valid;
  logic        rsp_valid, rsp_id, rsp_overflow, rsp_err, rsp_ready;
  logic [31:0] rsp_product;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  mini_alu_16bit_mul_arb #(.MUL_LAT(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_data0(mul_data0), .mul_data1(mul_data1),
    .mul_product(mul_product), .mul_overflow(mul_overflow), .mul_valid(mul_valid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'd1; req0_b = 16'd1; req1_a = 16'd2; req1_b = 16'd2;
    #1;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got %0h exp 0", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1 got %0h exp 0", req1_ready); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0h exp 0", busy); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %0h exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if ({mul_data0, mul_data1} !== 32'd0) $display("FAIL rst_mul_data got %0h exp 0", {mul_data0, mul_data1}); else pass_cnt++;
    total_cnt++; if ({rsp_id, rsp_product, rsp_overflow, rsp_err} !== 35'd0) $display("FAIL rst_rsp_fields got %0h exp 0", {rsp_id, rsp_product, rsp_overflow, rsp_err}); else pass_cnt++;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got %0b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    tick();
    total_cnt++; if ({mul_data0, mul_data1} !== {16'd3, 16'd5}) $display("FAIL single_mul_data got %0h exp 00030005", {mul_data0, mul_data1}); else pass_cnt++;
    total_cnt++; if ({busy, req0_ready} !== 2'b10) $display("FAIL single_wait got busy/ready %0b exp 10", {busy, req0_ready}); else pass_cnt++;
    req0_valid = 1'b0; mul_valid = 1'b1; mul_product = 32'd15;
    tick();
    mul_valid = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) $display("FAIL single_rsp_flags got %0b exp 100", {rsp_valid, rsp_id, rsp_err}); else pass_cnt++;
    total_cnt++; if (rsp_product !== 32'd15) $display("FAIL single_product got %0d exp 15", rsp_product); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done got %0b exp 00", {rsp_valid, busy}); else pass_cnt++;
    total_cnt++; if (rsp_product !== 32'd15) $display("FAIL single_hold got %0d exp 15", rsp_product); else pass_cnt++;
  endtask

  task automatic test_contention();
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd200;
    req1_valid = 1'b1; req1_a = 16'd7;   req1_b = 16'd9;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL cont_grant0 got %0b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    tick();
    total_cnt++; if ({mul_data0, mul_data1} !== {16'd100, 16'd200}) $display("FAIL cont_data0 got %0h exp 006400c8", {mul_data0, mul_data1}); else pass_cnt++;
    mul_valid = 1'b1; mul_product = 32'd20000;
    tick();
    mul_valid = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_product !== 32'd20000) $display("FAIL cont_rsp0 got v/id %0b prod %0d exp 10/20000", {rsp_valid, rsp_id}, rsp_product); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL cont_resp_ready got %0b exp 00", {req0_ready, req1_ready}); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL cont_grant1 got %0b exp 01", {req0_ready, req1_ready}); else pass_cnt++;
    tick();
    total_cnt++; if ({mul_data0, mul_data1} !== {16'd7, 16'd9}) $display("FAIL cont_data1 got %0h exp 00070009", {mul_data0, mul_data1}); else pass_cnt++;
    mul_valid = 1'b1; mul_product = 32'd63;
    tick();
    mul_valid = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_id} !== 2'b11 || rsp_product !== 32'd63) $display("FAIL cont_rsp1 got v/id %0b prod %0d exp 11/63", {rsp_valid, rsp_id}, rsp_product); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ids;
    ids = 6'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      mul_valid = 1'b1; mul_product = 32'(i * 11 + 1);
      tick();
      mul_valid = 1'b0;
      ids[i] = rsp_id;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_product !== 32'(i * 11 + 1)) $display("FAIL b2b_rsp%0d got v %0b prod %0d exp 1/%0d", i, rsp_valid, rsp_product, i * 11 + 1); else pass_cnt++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    total_cnt++; if (ids !== 6'b101010) $display("FAIL b2b_id_seq got %06b exp 101010", ids); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    tick();
    mul_valid = 1'b1; mul_product = 32'hFFFE0001; mul_overflow = 1'b1;
    tick();
    mul_valid = 1'b0; mul_product = 32'h0; mul_overflow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({rsp_valid, rsp_id, rsp_overflow, rsp_err} !== 4'b1010 || rsp_product !== 32'hFFFE0001 || req0_ready !== 1'b0)
        $display("FAIL bp_hold%0d got flags %04b prod %0h ready %0b exp 1010/fffe0001/0", i, {rsp_valid, rsp_id, rsp_overflow, rsp_err}, rsp_product, req0_ready);
      else pass_cnt++;
      tick();
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL bp_release got %0b exp 00", {rsp_valid, busy}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4; mul_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k < 15; k++) begin
      tick();
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL tmo_early%0d got %0b exp 0", k, rsp_valid); else pass_cnt++;
    end
    tick();
    total_cnt++; if ({rsp_valid, rsp_id, rsp_err, rsp_overflow} !== 4'b1110 || rsp_product !== 32'd0) $display("FAIL tmo_rsp got flags %04b prod %0h exp 1110/0", {rsp_valid, rsp_id, rsp_err, rsp_overflow}, rsp_product); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_capture_at_timeout();
    req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd3;
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    mul_valid = 1'b1; mul_product = 32'h1234;
    tick();
    mul_valid = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_product !== 32'h1234) $display("FAIL cap_vs_tmo got v/err %0b prod %0h exp 10/1234", {rsp_valid, rsp_err}, rsp_product); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd9;
    req1_valid = 1'b1; req1_a = 16'd8; req1_b = 16'd8;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_rst_ready got %0b exp 00", {req0_ready, req1_ready}); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if ({busy, rsp_valid} !== 2'b00 || {mul_data0, mul_data1} !== 32'd0) $display("FAIL mid_rst_state got %0b data %0h exp 00/0", {busy, rsp_valid}, {mul_data0, mul_data1}); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_rst_grant got %0b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    mul_product = '0; mul_overflow = 1'b0; mul_valid = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_capture_at_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
